findface_ctrl: RTL and testbench
================================

Name: findface_ctrl

Overview:
- Sequencer for the 32x32 SAD datapath in the findface core.
- Sweeps candidate window positions over the group image in raster order and requests each window from the window supplier.
- Tracks the fixed SAD pipeline latency with a tag shift register, compares each returned SAD, and keeps the minimum SAD and its (x,y) position.
- Sits between the slave-register/IPIF logic (start, config, result readback) and the window buffer plus SAD datapath.

Parameters:
- SAD_LATENCY, 4, cycles from the window-present cycle (win_ack) to the matching sad_in being valid.
- COORD_W, 8, width of candidate x/y coordinates.
- SAD_W, 32, width of sad_in and best_sad.

Ports:
- Bus2IP_Clk  in  1  system clock; all logic on its rising edge.
- Bus2IP_Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a search; ignored while busy=1.
- abort  in  1  cancels a search in progress.
- cfg_max_x  in  COORD_W  last candidate x, inclusive; sampled at start.
- cfg_max_y  in  COORD_W  last candidate y, inclusive; sampled at start.
- win_req  out  1  window request to the supplier.
- win_x  out  COORD_W  requested candidate x.
- win_y  out  COORD_W  requested candidate y.
- win_ack  in  1  the requested window is on the datapath group_data inputs this cycle.
- sad_in  in  SAD_W  SAD datapath output.
- busy  out  1  search in progress (ISSUE or DRAIN).
- done  out  1  one-cycle pulse when a search completes.
- result_valid  out  1  best_* outputs hold a complete search result.
- best_sad  out  SAD_W  minimum SAD found.
- best_x  out  COORD_W  x position of the minimum.
- best_y  out  COORD_W  y position of the minimum.

Behaviour:
- Reset: every output is 0; state IDLE; tag pipeline cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start:
  - latch cfg_max_x and cfg_max_y;
  - set x=0, y=0;
  - clear result_valid;
  - arm first-result flag.
- ISSUE:
  - win_req=1, with win_x/win_y held stable until win_ack.
  - On a win_ack cycle, push valid+tag(x,y) into stage 0 of the SAD_LATENCY-deep shift register.
  - Then advance in raster order: x increments; when x=max_x, x wraps to 0 and y increments.
  - An ack at (max_x,max_y) moves to DRAIN.
  - win_ack while win_req=0 is ignored.
- Tag register: shifts every cycle. The stage SAD_LATENCY-1 output aligns with sad_in (ack in cycle t -> sad_in valid in cycle t+SAD_LATENCY).
- Compare, on each cycle the tag at the output stage is valid:
  - The first result of a search loads best_* unconditionally.
  - After that, best_* updates only if sad_in < best_sad (strictly less), so ties keep the earliest raster position.
- DRAIN: win_req=0. Move to DONE when no valid tags remain in the pipeline, including the final compare.
- DONE: lasts one cycle; done=1 and result_valid=1, then return to IDLE.
- result_valid stays high until the next accepted start, abort, or reset.
- busy=1 in ISSUE and DRAIN only.
- abort, in any state: next cycle is IDLE, tags cleared, win_req=0, result_valid=0, no done pulse. best_* are left unchanged but are not valid.
- Reset mid-search behaves the same as abort, and additionally zeroes best_*.
- Simultaneous start and abort in IDLE: abort wins, search not started.
- cfg_max_x=cfg_max_y=0: exactly one candidate, (0,0).
- Coordinates never exceed the latched max; no wrap past max_y.
- Back-to-back acks (win_ack every cycle) are supported at full throughput: one candidate per cycle.

Test Plan:
- Reset with Bus2IP_Reset held 3 cycles -> all outputs 0, win_req=0, busy=0.
- cfg_max_x=2, cfg_max_y=1, win_ack tied high, sad_in stub returns 100,90,95,90,120,80 in raster order -> 6 requests, (0,0)..(2,1) in order. Result: best_sad=80, best_x=2, best_y=1. done pulses exactly once, SAD_LATENCY+1 cycles after the last ack.
- Tie: every sad_in=50 over a 3x3 sweep -> best_sad=50, best_x=0, best_y=0.
- Stalled supplier, win_ack every 3rd cycle, cfg 1x1 (max 0,0) -> win_x/win_y stable across stalls. One result; done 4 cycles after its ack plus DRAIN/DONE; best_sad equals the stubbed value.
- abort asserted two cycles into DRAIN -> IDLE next cycle; no done; result_valid=0. A new start then completes normally.
- start pulsed while busy -> ignored, and the sweep coordinates are unchanged. start together with abort in IDLE -> stays IDLE.

Source files
------------

// File: rtl/findface_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : findface_ctrl_if
// Description : Window-request / SAD-return bus between the findface search
//               sequencer (master) and the window supplier plus SAD datapath
//               (slave).
//                 win_req  master->slave  window request
//                 win_x    master->slave  requested candidate x
//                 win_y    master->slave  requested candidate y
//                 win_ack  slave->master  requested window is on the datapath
//                 sad_in   slave->master  SAD datapath output
// Revision    : 1.0  initial release
// ============================================================================
interface findface_ctrl_if #(
    parameter int COORD_W = 8,
    parameter int SAD_W   = 32
);
    logic               win_req;
    logic [COORD_W-1:0] win_x;
    logic [COORD_W-1:0] win_y;
    logic               win_ack;
    logic [SAD_W-1:0]   sad_in;

    modport master (
        output win_req,
        output win_x,
        output win_y,
        input  win_ack,
        input  sad_in
    );

    modport slave (
        input  win_req,
        input  win_x,
        input  win_y,
        output win_ack,
        output sad_in
    );
endinterface
`default_nettype wire

// File: rtl/findface_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : findface_ctrl
// Description : Sequencer for the 32x32 SAD datapath. Sweeps candidate window
//               positions in raster order, tracks the fixed SAD pipeline
//               latency with a tag shift register and keeps the minimum SAD
//               together with its (x,y) position.
// Ports       : Bus2IP_Clk / Bus2IP_Reset  clock, synchronous active-high reset
//               start, abort                search control
//               cfg_max_x, cfg_max_y        last candidate x/y (inclusive)
//               win (master modport)        window request / SAD return bus
//               busy, done, result_valid    status
//               best_sad, best_x, best_y    search result
// Revision    : 1.0  initial release
// ============================================================================
module findface_ctrl #(
    parameter int SAD_LATENCY = 4,
    parameter int COORD_W     = 8,
    parameter int SAD_W       = 32
) (
    input  wire logic               Bus2IP_Clk,
    input  wire logic               Bus2IP_Reset,
    input  wire logic               start,
    input  wire logic               abort,
    input  wire logic [COORD_W-1:0] cfg_max_x,
    input  wire logic [COORD_W-1:0] cfg_max_y,
    findface_ctrl_if.master         win,
    output logic                    busy,
    output logic                    done,
    output logic                    result_valid,
    output logic [SAD_W-1:0]        best_sad,
    output logic [COORD_W-1:0]      best_x,
    output logic [COORD_W-1:0]      best_y
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [COORD_W-1:0] r_max_x;
    logic [COORD_W-1:0] r_max_y;
    logic               r_first;

    // Tag pipeline: stage 0 is loaded on an accepted ack, stage
    // SAD_LATENCY-1 lines up with sad_in.
    logic [SAD_LATENCY-1:0] r_vld;
    logic [COORD_W-1:0]     r_tag_x [SAD_LATENCY];
    logic [COORD_W-1:0]     r_tag_y [SAD_LATENCY];

    logic                   w_ack;
    logic                   w_last_x;
    logic                   w_last_y;
    logic                   w_out_vld;
    logic                   w_take;
    logic [SAD_LATENCY-1:0] w_vld_upstream;

    assign w_ack     = win.win_req & win.win_ack;
    assign w_last_x  = (win.win_x == r_max_x);
    assign w_last_y  = (win.win_y == r_max_y);
    assign w_out_vld = r_vld[SAD_LATENCY-1];
    // Strict less-than keeps the earliest raster position on ties.
    assign w_take    = w_out_vld & (r_first | (win.sad_in < best_sad));

    // Valid bits of every stage except the output stage. When these are all
    // clear, the result being compared this cycle is the last one.
    assign w_vld_upstream = r_vld << 1;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_state      <= ST_IDLE;
            r_max_x      <= '0;
            r_max_y      <= '0;
            r_first      <= 1'b0;
            r_vld        <= '0;
            for (int i = 0; i < SAD_LATENCY; i++) begin
                r_tag_x[i] <= '0;
                r_tag_y[i] <= '0;
            end
            win.win_req  <= 1'b0;
            win.win_x    <= '0;
            win.win_y    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            best_sad     <= '0;
            best_x       <= '0;
            best_y       <= '0;
        end else if (abort) begin
            // best_* keep their contents but are marked invalid.
            r_state      <= ST_IDLE;
            r_vld        <= '0;
            win.win_req  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            done <= 1'b0;

            for (int i = SAD_LATENCY - 1; i > 0; i--) begin
                r_vld[i]   <= r_vld[i-1];
                r_tag_x[i] <= r_tag_x[i-1];
                r_tag_y[i] <= r_tag_y[i-1];
            end
            r_vld[0]   <= w_ack;
            r_tag_x[0] <= win.win_x;
            r_tag_y[0] <= win.win_y;

            if (w_take) begin
                best_sad <= win.sad_in;
                best_x   <= r_tag_x[SAD_LATENCY-1];
                best_y   <= r_tag_y[SAD_LATENCY-1];
                r_first  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_ISSUE;
                        r_max_x      <= cfg_max_x;
                        r_max_y      <= cfg_max_y;
                        r_first      <= 1'b1;
                        win.win_req  <= 1'b1;
                        win.win_x    <= '0;
                        win.win_y    <= '0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (w_ack) begin
                        if (w_last_x) begin
                            if (w_last_y) begin
                                win.win_req <= 1'b0;
                                r_state     <= ST_DRAIN;
                            end else begin
                                win.win_x <= '0;
                                win.win_y <= win.win_y + 1'b1;
                            end
                        end else begin
                            win.win_x <= win.win_x + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_vld_upstream == '0) begin
                        r_state      <= ST_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_findface_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_findface_ctrl
// Description : Self-checking bench for findface_ctrl. A table of sweep
//               vectors with hand-computed results is run through a window
//               supplier / SAD stub, plus directed abort and reset sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_findface_ctrl;

    localparam int L  = 4;
    localparam int CW = 8;
    localparam int SW = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_max_x;
    logic [CW-1:0] cfg_max_y;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [SW-1:0] best_sad;
    logic [CW-1:0] best_x;
    logic [CW-1:0] best_y;

    findface_ctrl_if #(.COORD_W(CW), .SAD_W(SW)) win ();

    findface_ctrl #(.SAD_LATENCY(L), .COORD_W(CW), .SAD_W(SW)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .start        (start),
        .abort        (abort),
        .cfg_max_x    (cfg_max_x),
        .cfg_max_y    (cfg_max_y),
        .win          (win),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .best_sad     (best_sad),
        .best_x       (best_x),
        .best_y       (best_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- supplier / SAD stub and observers ----------------
    logic          tb_clr;
    logic [SW-1:0] stub_vals [16];
    int            stub_idx;
    logic [SW-1:0] dly [L];
    int            ack_cnt;
    logic [CW-1:0] ack_xs [32];
    logic [CW-1:0] ack_ys [32];
    int            done_cnt;
    int            cyc;
    int            last_ack_cyc;
    int            done_cyc;

    // Non-acked slots carry 0 so a DUT that compares untagged cycles would
    // pick it up as a new minimum.
    assign win.sad_in = dly[L-1];

    initial begin
        cyc = 0; stub_idx = 0; ack_cnt = 0; done_cnt = 0;
        last_ack_cyc = 0; done_cyc = 0;
        for (int i = 0; i < L; i++) dly[i] = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = L - 1; i > 0; i--) dly[i] <= dly[i-1];
        if (win.win_req && win.win_ack && stub_idx < 16)
            dly[0] <= stub_vals[stub_idx];
        else
            dly[0] <= '0;
        if (tb_clr) begin
            stub_idx <= 0;
            ack_cnt  <= 0;
            done_cnt <= 0;
        end else begin
            if (win.win_req && win.win_ack) begin
                stub_idx     <= stub_idx + 1;
                last_ack_cyc <= cyc;
                if (ack_cnt < 32) begin
                    ack_xs[ack_cnt] <= win.win_x;
                    ack_ys[ack_cnt] <= win.win_y;
                end
                ack_cnt <= ack_cnt + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [CW-1:0]       mx;
        logic [CW-1:0]       my;
        int                  period;  // win_ack every period-th cycle
        int                  poke;    // cycle index for a start pulse while busy, -1 none
        int                  n;
        logic [0:8][SW-1:0]  sads;
        logic [SW-1:0]       esad;
        logic [CW-1:0]       ex;
        logic [CW-1:0]       ey;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int phase;
        logic prev_req, prev_ack;
        logic [CW-1:0] prev_x, prev_y;
        int stall_err, ord_err;
        for (int i = 0; i < 9; i++) stub_vals[i] = v.sads[i];
        cfg_max_x = v.mx;
        cfg_max_y = v.my;
        tb_clr    = 1'b1;
        tick();
        tb_clr = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_rv_cleared"}, result_valid, 0);
        chk({tag, "_first_coord"}, {win.win_req, win.win_x, win.win_y}, {1'b1, 8'd0, 8'd0});
        phase = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_x = '0; prev_y = '0;
        stall_err = 0;
        for (int k = 0; k < 300; k++) begin
            if (prev_req && !prev_ack && win.win_req &&
                (win.win_x != prev_x || win.win_y != prev_y))
                stall_err++;
            prev_req = win.win_req;
            prev_x   = win.win_x;
            prev_y   = win.win_y;
            win.win_ack = (phase == v.period - 1);
            prev_ack    = win.win_ack;
            phase       = (phase + 1) % v.period;
            start       = (k == v.poke);
            tick();
            start = 1'b0;
            if (done_cnt != 0) break;
        end
        win.win_ack = 1'b0;
        chk({tag, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) tick();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_done_latency"}, done_cyc - last_ack_cyc, L + 1);
        chk({tag, "_ack_count"}, ack_cnt, v.n);
        ord_err = 0;
        for (int i = 0; i < v.n && i < 32; i++) begin
            if (ack_xs[i] != CW'(i % (int'(v.mx) + 1)) ||
                ack_ys[i] != CW'(i / (int'(v.mx) + 1)))
                ord_err++;
        end
        chk({tag, "_raster_order"}, ord_err, 0);
        chk({tag, "_stall_stable"}, stall_err, 0);
        chk({tag, "_best_sad"}, best_sad, v.esad);
        chk({tag, "_best_xy"}, {best_x, best_y}, {v.ex, v.ey});
        chk({tag, "_rv_held"}, result_valid, 1);
        chk({tag, "_idle"}, {busy, win.win_req}, 0);
    endtask

    initial begin
        int w;
        vecs[0] = '{mx: 8'd2, my: 8'd1, period: 1, poke: -1, n: 6,
                    sads: {32'd100, 32'd90, 32'd95, 32'd90, 32'd120, 32'd80, 32'd0, 32'd0, 32'd0},
                    esad: 32'd80, ex: 8'd2, ey: 8'd1};
        vecs[1] = '{mx: 8'd2, my: 8'd2, period: 1, poke: -1, n: 9,
                    sads: {32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50},
                    esad: 32'd50, ex: 8'd0, ey: 8'd0};
        vecs[2] = '{mx: 8'd0, my: 8'd2, period: 1, poke: -1, n: 3,
                    sads: {32'd10, 32'd20, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                    esad: 32'd5, ex: 8'd0, ey: 8'd2};
        vecs[3] = '{mx: 8'd0, my: 8'd0, period: 3, poke: -1, n: 1,
                    sads: {32'd77, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                    esad: 32'd77, ex: 8'd0, ey: 8'd0};
        vecs[4] = '{mx: 8'd2, my: 8'd2, period: 3, poke: 4, n: 9,
                    sads: {32'd60, 32'd40, 32'd70, 32'd40, 32'd30, 32'd90, 32'd30, 32'd55, 32'd31},
                    esad: 32'd30, ex: 8'd1, ey: 8'd1};
        vecs[5] = '{mx: 8'd3, my: 8'd0, period: 2, poke: -1, n: 4,
                    sads: {32'd5, 32'd4, 32'd3, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                    esad: 32'd2, ex: 8'd3, ey: 8'd0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; tb_clr = 1'b1;
        cfg_max_x = '0; cfg_max_y = '0; win.win_ack = 1'b0;
        for (int i = 0; i < 16; i++) stub_vals[i] = '0;

        // Reset held three cycles.
        repeat (3) tick();
        chk("reset_status", {busy, done, result_valid, win.win_req}, 0);
        chk("reset_coord", {win.win_x, win.win_y}, 0);
        chk("reset_best", {best_sad, best_x, best_y}, 0);
        rst = 1'b0;
        tb_clr = 1'b0;
        tick();

        run_vec(vecs[0], "v2x1");
        run_vec(vecs[1], "tie3x3");

        // Abort two cycles into DRAIN.
        cfg_max_x = 8'd1; cfg_max_y = 8'd0;
        tb_clr = 1'b1; tick(); tb_clr = 1'b0;
        start = 1'b1; win.win_ack = 1'b1; tick(); start = 1'b0;
        w = 0;
        while (!(busy && !win.win_req) && w < 20) begin tick(); w++; end
        chk("abort_reach_drain", (w < 20), 1);
        tick();
        abort = 1'b1; tick(); abort = 1'b0; win.win_ack = 1'b0;
        chk("abort_idle", {busy, win.win_req, result_valid, done}, 0);
        repeat (8) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stay_idle", {busy, result_valid}, 0);

        run_vec(vecs[2], "col");
        run_vec(vecs[3], "stall1x1");

        // start together with abort in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, win.win_req, result_valid}, 0);
        tick();
        chk("start_abort_stay", {busy, win.win_req}, 0);

        run_vec(vecs[4], "poke3x3");
        run_vec(vecs[5], "row");

        // Reset mid-search zeroes best_* and stops the sweep.
        cfg_max_x = 8'd2; cfg_max_y = 8'd2;
        start = 1'b1; win.win_ack = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0; win.win_ack = 1'b0;
        chk("midreset_status", {busy, win.win_req, result_valid, done}, 0);
        chk("midreset_best", {best_sad, best_x, best_y}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
